prbs_checker: RTL and testbench

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 163 ++++++++++++++++
 tb/tb_prbs_checker.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/prbs_checker.sv
// PRBS7 (x^7+x^6+1) receive checker: self-seeds from the incoming stream, then counts checked bits and errors.
// Define PRBS_CHECKER_LOSS_DETECT_EN to add windowed loss-of-lock detection with automatic reseed.
module prbs_checker #(
    parameter int CNT_WIDTH = 32,
    parameter int WIN_LOG2  = 6,
    parameter int ERR_THR   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 in,
    input  logic                 clear,
    output logic                 locked,
    output logic [CNT_WIDTH-1:0] bit_count,
    output logic [CNT_WIDTH-1:0] err_count,
    output logic [7:0]           relock_count,
    output logic                 err
);

`ifdef PRBS_CHECKER_LOSS_DETECT_EN
    typedef enum logic [1:0] {SEED, CHECK, LOST} state_t;
    localparam int WERR_W = $clog2(ERR_THR + 1);
    localparam logic [WIN_LOG2-1:0] WIN_ONE = 1;
`else
    typedef enum logic {SEED, CHECK} state_t;
`endif

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;

    state_t                 state_q, state_d;
    logic [6:0]             sr_q, sr_d;
    logic [2:0]             seed_cnt_q, seed_cnt_d;
    logic                   locked_q, locked_d;
    logic                   err_q, err_d;
    logic [CNT_WIDTH-1:0]   bit_count_q, bit_count_d;
    logic [CNT_WIDTH-1:0]   err_count_q, err_count_d;
    logic                   pred;
    logic                   mism;
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
    logic [7:0]             relock_q, relock_d;
    logic [WIN_LOG2-1:0]    win_cnt_q, win_cnt_d;
    logic [WERR_W-1:0]      win_err_q, win_err_d;
    logic [WERR_W:0]        win_err_inc;
`endif

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    assign pred = sr_q[6] ^ sr_q[5];
    assign mism = in ^ pred;

    always_comb begin
        // NOTE: every next-state value gets its hold default first, so no path leaves it unassigned (no latch).
        state_d     = state_q;
        sr_d        = sr_q;
        seed_cnt_d  = seed_cnt_q;
        err_d       = err_q;
        bit_count_d = bit_count_q;
        err_count_d = err_count_q;
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
        relock_d    = relock_q;
        win_cnt_d   = win_cnt_q;
        win_err_d   = win_err_q;
        win_err_inc = {1'b0, win_err_q} + {{WERR_W{1'b0}}, mism};
`endif

        case (state_q)
            SEED: begin
                err_d = 1'b0;
                if (en) begin
                    sr_d = {sr_q[5:0], in};
                    if (seed_cnt_q == 3'd6) begin
                        // An all-zero seed would lock the LFSR at zero forever, so seed again.
                        seed_cnt_d = 3'd0;
                        if (sr_d != 7'd0) state_d = CHECK;
                    end else begin
                        seed_cnt_d = seed_cnt_q + 3'd1;
                    end
                end
            end
            CHECK: begin
                if (en) begin
                    err_d       = mism;
                    sr_d        = {sr_q[5:0], pred};
                    bit_count_d = sat_inc(bit_count_q);
                    if (mism) err_count_d = sat_inc(err_count_q);
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
                    if (win_err_inc >= (WERR_W + 1)'(ERR_THR)) begin
                        state_d = LOST;
                    end else if (&win_cnt_q) begin
                        win_cnt_d = '0;
                        win_err_d = '0;
                    end else begin
                        win_cnt_d = win_cnt_q + WIN_ONE;
                        win_err_d = win_err_inc[WERR_W-1:0];
                    end
`endif
                end
            end
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
            LOST: begin
                err_d      = 1'b0;
                relock_d   = (&relock_q) ? relock_q : relock_q + 8'd1;
                seed_cnt_d = 3'd0;
                win_cnt_d  = '0;
                win_err_d  = '0;
                state_d    = SEED;
            end
`endif
            default: state_d = SEED;
        endcase

        if (clear) begin
            bit_count_d = '0;
            err_count_d = '0;
        end

        locked_d = (state_d == CHECK);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= SEED;
            sr_q        <= 7'd0;
            seed_cnt_q  <= 3'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            bit_count_q <= '0;
            err_count_q <= '0;
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
            relock_q    <= 8'd0;
            win_cnt_q   <= '0;
            win_err_q   <= '0;
`endif
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            seed_cnt_q  <= seed_cnt_d;
            locked_q    <= locked_d;
            err_q       <= err_d;
            bit_count_q <= bit_count_d;
            err_count_q <= err_count_d;
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
            relock_q    <= relock_d;
            win_cnt_q   <= win_cnt_d;
            win_err_q   <= win_err_d;
`endif
        end
    end

    assign locked    = locked_q;
    assign err       = err_q;
    assign bit_count = bit_count_q;
    assign err_count = err_count_q;
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_prbs_checker.sv
// Directed bench for prbs_checker: seeding, error counting, clear, en gating, loss handling, saturation, async reset.
module tb_prbs_checker;

    localparam int CW = 10;
    localparam int CNT_MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          din;
    logic          clear;
    logic          locked;
    logic [CW-1:0] bit_count;
    logic [CW-1:0] err_count;
    logic [7:0]    relock_count;
    logic          err;

    int         n_cmp  = 0;
    int         n_fail = 0;
    logic [6:0] g      = 7'h01;
    int         k      = 0;
    int         exp_bits = 0;
    bit         in_check = 0;
    bit         any_err;

    prbs_checker #(.CNT_WIDTH(CW), .WIN_LOG2(6), .ERR_THR(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .in           (din),
        .clear        (clear),
        .locked       (locked),
        .bit_count    (bit_count),
        .err_count    (err_count),
        .relock_count (relock_count),
        .err          (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: when e=1 the next PRBS bit (optionally inverted) is driven; when use_gen=0 a random bit.
    task automatic chk_bit(input logic flip, input logic e, input logic c, input bit use_gen);
        logic b;
        if (e && use_gen) begin
            b = g[6] ^ g[5];
            g = {g[5:0], b};
            din = b ^ flip;
        end else begin
            din = 1'($urandom_range(0, 1));
        end
        en    = e;
        clear = c;
        if (e && in_check) begin
            k++;
            if (exp_bits < CNT_MAX) exp_bits++;
        end
        if (c) exp_bits = 0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        din   = 1'b0;
        clear = 1'b0;
        #3;
        check("rst_locked", 32'(locked), 0);
        check("rst_bits", 32'(bit_count), 0);
        check("rst_errs", 32'(err_count), 0);
        check("rst_relock", 32'(relock_count), 0);
        check("rst_err", 32'(err), 0);
        #9 rst_n = 1'b1;

        // All-zero stream: three full seed attempts, each rejected.
        for (int i = 0; i < 21; i++) begin
            en = 1'b1; din = 1'b0; clear = 1'b0;
            @(posedge clk); #1;
        end
        check("zero_locked", 32'(locked), 0);
        check("zero_bits", 32'(bit_count), 0);

        // Ideal stream: 1000 en cycles, lock visible after the 7th.
        for (int i = 1; i <= 6; i++) chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("seed6_locked", 32'(locked), 0);
        chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("seed7_locked", 32'(locked), 1);
        in_check = 1;
        any_err  = 0;
        for (int i = 0; i < 993; i++) begin
            chk_bit(1'b0, 1'b1, 1'b0, 1);
            if (err !== 1'b0) any_err = 1;
        end
        check("ideal_any_err", 32'(any_err), 0);
        check("ideal_bits", 32'(bit_count), 993);
        check("ideal_errs", 32'(err_count), 0);
        check("ideal_locked", 32'(locked), 1);

        // Single inverted bit.
        chk_bit(1'b1, 1'b1, 1'b0, 1);
        check("single_err", 32'(err), 1);
        check("single_errs", 32'(err_count), 1);
        check("single_bits", 32'(bit_count), 994);
        chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("single_err_clr", 32'(err), 0);
        check("single_errs_hold", 32'(err_count), 1);
        check("single_locked", 32'(locked), 1);

        // Clear coinciding with a mismatch: clear wins on both counters.
        chk_bit(1'b1, 1'b1, 1'b1, 1);
        check("clr_err", 32'(err), 1);
        check("clr_errs", 32'(err_count), 0);
        check("clr_bits", 32'(bit_count), 0);

        // en toggled 50%: only en=1 cycles count, err holds on en=0.
        for (int i = 0; i < 10; i++) begin
            chk_bit(1'b0, 1'(i % 2), 1'b0, 1);
            if (i == 0) check("tog_err_hold", 32'(err), 1);
        end
        check("tog_bits", 32'(bit_count), 5);
        check("tog_errs", 32'(err_count), 0);
        check("tog_err", 32'(err), 0);

        // Align to a window boundary, then inject 8 consecutive errors.
        while (k % 64 != 0) chk_bit(1'b0, 1'b1, 1'b0, 1);
        for (int i = 0; i < 7; i++) chk_bit(1'b1, 1'b1, 1'b0, 1);
        check("burst7_locked", 32'(locked), 1);
        check("burst7_errs", 32'(err_count), 7);
        chk_bit(1'b1, 1'b1, 1'b0, 1);
        check("burst8_errs", 32'(err_count), 8);
`ifdef PRBS_CHECKER_LOSS_DETECT_EN
        check("burst8_locked", 32'(locked), 0);
        check("burst8_relock", 32'(relock_count), 0);
        in_check = 0;
        chk_bit(1'b0, 1'b1, 1'b0, 0);
        check("lost_relock", 32'(relock_count), 1);
        check("lost_locked", 32'(locked), 0);
        check("lost_err", 32'(err), 0);
        for (int i = 0; i < 6; i++) chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("reseed6_locked", 32'(locked), 0);
        chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("reseed7_locked", 32'(locked), 1);
        in_check = 1;
        k = 0;
`else
        check("burst8_locked", 32'(locked), 1);
        check("burst8_relock", 32'(relock_count), 0);
`endif
        chk_bit(1'b0, 1'b1, 1'b0, 1);
        chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("post_errs", 32'(err_count), 8);
        check("post_err", 32'(err), 0);
        check("post_locked", 32'(locked), 1);
        check("post_bits", 32'(bit_count), 32'(exp_bits));

        // Saturation of bit_count at all-ones.
        while (exp_bits < CNT_MAX - 1) chk_bit(1'b0, 1'b1, 1'b0, 1);
        check("sat_pre", 32'(bit_count), CNT_MAX - 1);
        for (int i = 0; i < 3; i++) begin
            chk_bit(1'b0, 1'b1, 1'b0, 1);
            check("sat_hold", 32'(bit_count), CNT_MAX);
        end
        check("sat_errs", 32'(err_count), 8);

        // Asynchronous reset in the middle of a clock-high phase.
        #2 rst_n = 1'b0;
        #1;
        check("arst_locked", 32'(locked), 0);
        check("arst_bits", 32'(bit_count), 0);
        check("arst_errs", 32'(err_count), 0);
        check("arst_relock", 32'(relock_count), 0);
        check("arst_err", 32'(err), 0);
        #10 rst_n = 1'b1;
        @(posedge clk); #1;
        check("arst_after_locked", 32'(locked), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
